// File: rtl/rx_ltssm_pkg.sv
// Shared constants for ordered-set handling: TS symbol values, symbol byte
// offsets inside a 128-bit ordered set, and the qualifier FSM encoding.
package rx_ltssm_pkg;

    localparam int OS_W = 128;

    localparam logic [7:0] TS1_SYM0 = 8'h1E;
    localparam logic [7:0] TS2_SYM0 = 8'h2D;

    localparam int SYM_OS_ID      = 0;
    localparam int SYM_LINK       = 1;
    localparam int SYM_LANE       = 2;
    localparam int SYM_RATE       = 4;
    localparam int RATE_UPCFG_BIT = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [7:0] os_sym(input logic [OS_W-1:0] os, input int k);
        return os[k*8 +: 8];
    endfunction

endpackage

// File: rtl/rx_os_qualifier_if.sv
// Control/status bundle between the link-training controller and the
// ordered-set qualifier.
interface rx_os_qualifier_if
    import rx_ltssm_pkg::*;
#(
    parameter int LANES = 16,
    parameter int CNT_W = 5,
    parameter int TMR_W = 24
) ();

    logic [LANES*OS_W-1:0] orderedSets;
    logic                  validOrderedSets;
    logic                  start;
    logic                  abort;
    logic [7:0]            expectedOs;
    logic [7:0]            linkNumber;
    logic                  checkLink;
    logic                  checkLane;
    logic [CNT_W-1:0]      threshold;
    logic [4:0]            requiredLanes;
    logic [TMR_W-1:0]      timeoutCycles;

    logic                  busy;
    logic                  done;
    logic                  success;
    logic                  timedOut;
    logic [LANES-1:0]      laneQualified;
    logic [4:0]            qualifiedCount;
    logic [7:0]            rateId;
    logic                  upConfigureCapability;

    modport master (
        output orderedSets, validOrderedSets, start, abort, expectedOs, linkNumber,
               checkLink, checkLane, threshold, requiredLanes, timeoutCycles,
        input  busy, done, success, timedOut, laneQualified, qualifiedCount,
               rateId, upConfigureCapability
    );

    modport slave (
        input  orderedSets, validOrderedSets, start, abort, expectedOs, linkNumber,
               checkLink, checkLane, threshold, requiredLanes, timeoutCycles,
        output busy, done, success, timedOut, laneQualified, qualifiedCount,
               rateId, upConfigureCapability
    );

endinterface

// File: rtl/rx_os_lane_counter.sv
// One lane of the qualifier: ordered-set match, consecutive-match counter
// and the threshold compare that marks the lane as qualified.
module rx_os_lane_counter
    import rx_ltssm_pkg::*;
#(
    parameter int CNT_W    = 5,
    parameter int LANE_IDX = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OS_W-1:0]  os_i,
    input  logic             valid_i,
    input  logic [7:0]       expected_os_i,
    input  logic [7:0]       link_number_i,
    input  logic             check_link_i,
    input  logic             check_lane_i,
    input  logic [CNT_W-1:0] threshold_i,
    input  logic             enable_i,
    input  logic             clear_i,
    output logic             qualified_o
);

    localparam logic [7:0] LANE_ID = 8'(LANE_IDX);

    logic             match;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] thr_eff;

    always_comb begin
        match = valid_i
             && (os_sym(os_i, SYM_OS_ID) == expected_os_i)
             && (!check_link_i || (os_sym(os_i, SYM_LINK) == link_number_i))
             && (!check_lane_i || (os_sym(os_i, SYM_LANE) == LANE_ID));
    end

    // Clear beats counting; without a new ordered set the count simply holds.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && valid_i) begin
            if (!match) begin
                cnt_d = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        thr_eff     = (threshold_i == '0) ? CNT_W'(1) : threshold_i;
        qualified_o = (cnt_q >= thr_eff);
    end

endmodule

// File: rtl/rx_os_qualifier.sv
// Multi-lane ordered-set qualifier: waits until enough lanes have seen the
// expected OS back-to-back, or gives up after a programmable timeout.
module rx_os_qualifier
    import rx_ltssm_pkg::*;
#(
    parameter int LANES = 16,
    parameter int CNT_W = 5,
    parameter int TMR_W = 24
) (
    input logic              clk,
    input logic              reset,
    rx_os_qualifier_if.slave bus
);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             success_q, success_d;
    logic             timed_out_q, timed_out_d;
    logic             done_q, done_d;
    logic [7:0]       rate_id_q, rate_id_d;
    logic             upcfg_q, upcfg_d;

    logic [LANES-1:0] lane_qual;
    logic [4:0]       qual_cnt;
    logic [4:0]       req_eff;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             hit_success;
    logic             hit_timeout;
    logic [OS_W-1:0]  cap_os;
    logic [7:0]       cap_rate;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        rx_os_lane_counter #(
            .CNT_W    (CNT_W),
            .LANE_IDX (i)
        ) u_lane (
            .clk           (clk),
            .reset         (reset),
            .os_i          (bus.orderedSets[i*OS_W +: OS_W]),
            .valid_i       (bus.validOrderedSets),
            .expected_os_i (bus.expectedOs),
            .link_number_i (bus.linkNumber),
            .check_link_i  (bus.checkLink),
            .check_lane_i  (bus.checkLane),
            .threshold_i   (bus.threshold),
            .enable_i      (cnt_enable),
            .clear_i       (cnt_clear),
            .qualified_o   (lane_qual[i])
        );
    end

    always_comb begin
        qual_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            qual_cnt = qual_cnt + 5'(lane_qual[i]);
        end
    end

    // Lowest-index qualified lane supplies the captured rate fields.
    always_comb begin
        cap_os = bus.orderedSets[OS_W-1:0];
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_qual[i]) begin
                cap_os = bus.orderedSets[i*OS_W +: OS_W];
            end
        end
        cap_rate = os_sym(cap_os, SYM_RATE);
    end

    always_comb begin
        req_eff     = (bus.requiredLanes == '0) ? 5'd1 : bus.requiredLanes;
        hit_success = (qual_cnt >= req_eff);
        hit_timeout = (bus.timeoutCycles != '0)
                   && (timer_q == (bus.timeoutCycles - TMR_W'(1)));
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        success_d   = success_q;
        timed_out_d = timed_out_q;
        done_d      = 1'b0;
        rate_id_d   = rate_id_q;
        upcfg_d     = upcfg_q;
        cnt_clear   = 1'b0;
        cnt_enable  = (state_q == ST_RUN);

        if (bus.abort) begin
            state_d   = ST_IDLE;
            cnt_clear = 1'b1;
        end else if (bus.start) begin
            // Same restart from every state, including a re-start while running.
            state_d     = ST_RUN;
            cnt_clear   = 1'b1;
            timer_d     = '0;
            success_d   = 1'b0;
            timed_out_d = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (timer_q != '1) begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                    if (hit_success) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        success_d = 1'b1;
                        rate_id_d = cap_rate;
                        upcfg_d   = cap_rate[RATE_UPCFG_BIT];
                    end else if (hit_timeout) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        timed_out_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            success_q   <= 1'b0;
            timed_out_q <= 1'b0;
            done_q      <= 1'b0;
            rate_id_q   <= '0;
            upcfg_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            success_q   <= success_d;
            timed_out_q <= timed_out_d;
            done_q      <= done_d;
            rate_id_q   <= rate_id_d;
            upcfg_q     <= upcfg_d;
        end
    end

    always_comb begin
        bus.busy                  = (state_q == ST_RUN);
        bus.done                  = done_q;
        bus.success               = success_q;
        bus.timedOut              = timed_out_q;
        bus.laneQualified         = lane_qual;
        bus.qualifiedCount        = qual_cnt;
        bus.rateId                = rate_id_q;
        bus.upConfigureCapability = upcfg_q;
    end

endmodule

// File: tb/tb_rx_os_qualifier.sv
// Directed and randomized bench for rx_os_qualifier, checked against a
// streak-based reference model of the qualification rules.
module tb_rx_os_qualifier;
    import rx_ltssm_pkg::*;

    localparam int LANES = 4;
    localparam int CNT_W = 5;
    localparam int TMR_W = 24;
    localparam int MAXC  = 64;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;

    rx_os_qualifier_if #(.LANES(LANES), .CNT_W(CNT_W), .TMR_W(TMR_W)) bus ();

    rx_os_qualifier #(.LANES(LANES), .CNT_W(CNT_W), .TMR_W(TMR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [127:0] os_tab  [0:MAXC][0:LANES-1];
    bit           vld_tab [0:MAXC];

    logic [7:0]       cfg_exp;
    logic [7:0]       cfg_link;
    bit               cfg_chk_link;
    bit               cfg_chk_lane;
    int               cfg_thr;
    int               cfg_req;
    int               cfg_tmo;
    logic [7:0]       exp_rate;
    bit               exp_upcfg;
    int               dut_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_os(input int lane, input bit good, input logic [7:0] b4);
        logic [127:0] os;
        os = {$urandom, $urandom, $urandom, $urandom};
        os[7:0]   = cfg_exp;
        os[15:8]  = cfg_link;
        os[23:16] = 8'(lane);
        os[39:32] = b4;
        if (!good) begin
            case ($urandom_range(2))
                0:       os[7:0]   = os[7:0] ^ 8'h33;
                1:       os[15:8]  = os[15:8] ^ 8'h01;
                default: os[23:16] = os[23:16] ^ 8'h02;
            endcase
        end
        return os;
    endfunction

    task automatic fill_good(input int ncyc);
        for (int e = 0; e <= ncyc; e++) begin
            vld_tab[e] = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                os_tab[e][l] = mk_os(l, 1'b1, (l == 0) ? 8'h5F : 8'h0F);
            end
        end
    endtask

    // Reference model: a lane's count is the run of matching ordered sets since
    // the last valid non-matching one (invalid cycles are skipped).
    function automatic bit lane_match(input int e, input int l);
        logic [127:0] os;
        os = os_tab[e][l];
        return vld_tab[e] && (os[7:0] == cfg_exp)
            && (!cfg_chk_link || (os[15:8] == cfg_link))
            && (!cfg_chk_lane || (os[23:16] == 8'(l)));
    endfunction

    function automatic int streak(input int l, input int e);
        int s;
        bit stop;
        s = 0;
        stop = 1'b0;
        for (int k = e; k >= 1 && !stop; k--) begin
            if (vld_tab[k]) begin
                if (lane_match(k, l)) s++;
                else stop = 1'b1;
            end
        end
        return (s > CMAX) ? CMAX : s;
    endfunction

    function automatic logic [LANES-1:0] model_lq(input int e);
        logic [LANES-1:0] r;
        int thr;
        thr = (cfg_thr == 0) ? 1 : cfg_thr;
        for (int l = 0; l < LANES; l++) r[l] = (streak(l, e) >= thr);
        return r;
    endfunction

    task automatic model_end(input int ncyc, output int me, output bit msucc, output int mcap);
        int reqeff;
        logic [LANES-1:0] lq;
        me = -1;
        msucc = 1'b0;
        mcap = 0;
        reqeff = (cfg_req == 0) ? 1 : cfg_req;
        for (int e = 1; e <= ncyc && me < 0; e++) begin
            lq = model_lq(e - 1);
            if ($countones(lq) >= reqeff) begin
                me = e;
                msucc = 1'b1;
                for (int l = LANES - 1; l >= 0; l--) if (lq[l]) mcap = l;
            end else if (cfg_tmo != 0 && e == cfg_tmo) begin
                me = e;
            end
        end
    endtask

    task automatic apply_cfg();
        bus.expectedOs    = cfg_exp;
        bus.linkNumber    = cfg_link;
        bus.checkLink     = cfg_chk_link;
        bus.checkLane     = cfg_chk_lane;
        bus.threshold     = CNT_W'(cfg_thr);
        bus.requiredLanes = 5'(cfg_req);
        bus.timeoutCycles = TMR_W'(cfg_tmo);
    endtask

    task automatic run_case(input int ncyc, input bit end_abort, output int got_e);
        int me, mcap;
        bit msucc;
        bit fin;
        logic [LANES-1:0] lq;
        model_end(ncyc, me, msucc, mcap);
        apply_cfg();
        got_e = -1;
        fin = 1'b0;
        bus.start = 1'b1;
        bus.validOrderedSets = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_done", bus.done, 0);
        chk("start_lq", bus.laneQualified, 0);
        for (int e = 1; e <= ncyc && !fin; e++) begin
            for (int l = 0; l < LANES; l++) bus.orderedSets[l*128 +: 128] = os_tab[e][l];
            bus.validOrderedSets = vld_tab[e];
            @(posedge clk); #1;
            if (bus.done === 1'b1 && got_e < 0) got_e = e;
            lq = model_lq(e);
            chk("lane_qualified", bus.laneQualified, lq);
            chk("qualified_count", bus.qualifiedCount, $countones(lq));
            if (e == me) begin
                fin = 1'b1;
                if (msucc) begin
                    exp_rate  = os_tab[e][mcap][39:32];
                    exp_upcfg = exp_rate[6];
                end
                chk("done_pulse", bus.done, 1);
                chk("done_busy", bus.busy, 0);
                chk("success", bus.success, msucc);
                chk("timed_out", bus.timedOut, !msucc);
                chk("rate_id", bus.rateId, exp_rate);
                chk("upcfg", bus.upConfigureCapability, exp_upcfg);
            end else begin
                chk("run_done", bus.done, 0);
                chk("run_busy", bus.busy, 1);
            end
        end
        bus.validOrderedSets = 1'b0;
        if (me > 0) begin
            @(posedge clk); #1;
            chk("done_one_cycle", bus.done, 0);
            chk("done_hold_succ", bus.success, msucc);
            chk("done_hold_busy", bus.busy, 0);
            chk("done_hold_lq", bus.laneQualified, model_lq(me));
        end else if (end_abort) begin
            bus.abort = 1'b1;
            @(posedge clk); #1;
            bus.abort = 1'b0;
            chk("abort_busy", bus.busy, 0);
            chk("abort_lq", bus.laneQualified, 0);
        end
    endtask

    task automatic set_default_cfg();
        cfg_exp = TS1_SYM0;
        cfg_link = 8'h05;
        cfg_chk_link = 1'b1;
        cfg_chk_lane = 1'b1;
        cfg_thr = 8;
        cfg_req = 4;
        cfg_tmo = 0;
    endtask

    initial begin
        reset = 1'b0;
        bus.orderedSets = '0;
        bus.validOrderedSets = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_default_cfg();
        apply_cfg();
        exp_rate = 8'h00;
        exp_upcfg = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_success", bus.success, 0);
        chk("rst_timedout", bus.timedOut, 0);
        chk("rst_lq", bus.laneQualified, 0);
        chk("rst_rate", bus.rateId, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // All lanes TS1 every cycle, lane 0 carries the rate byte.
        fill_good(20);
        run_case(20, 1'b1, dut_e);
        chk("all_match_done_edge", dut_e, 9);
        chk("all_match_qc", bus.qualifiedCount, 4);
        chk("all_match_rate", bus.rateId, 8'h5F);
        chk("all_match_upcfg", bus.upConfigureCapability, 1);

        // Lane 2 wrong link number on its 5th ordered set.
        fill_good(25);
        os_tab[5][2][15:8] = 8'hA5;
        run_case(25, 1'b1, dut_e);
        chk("bad_link_done_edge", dut_e, 14);

        // Lane 3 never matches; ends by timeout.
        cfg_tmo = 20;
        fill_good(30);
        for (int e = 0; e <= 30; e++) os_tab[e][3][7:0] = TS2_SYM0;
        run_case(30, 1'b1, dut_e);
        chk("timeout_done_edge", dut_e, 20);
        chk("timeout_flag", bus.timedOut, 1);
        chk("timeout_lq", bus.laneQualified, 4'b0111);

        // Final match on the timeout cycle: success wins.
        cfg_tmo = 9;
        fill_good(20);
        run_case(20, 1'b1, dut_e);
        chk("tie_done_edge", dut_e, 9);
        chk("tie_success", bus.success, 1);
        chk("tie_timedout", bus.timedOut, 0);

        // abort and start together from DONE: abort dominates.
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_dominates_busy", bus.busy, 0);
        chk("abort_dominates_lq", bus.laneQualified, 0);

        // Restart while running.
        cfg_tmo = 0;
        fill_good(5);
        run_case(5, 1'b0, dut_e);
        fill_good(20);
        run_case(20, 1'b1, dut_e);
        chk("restart_done_edge", dut_e, 9);

        // Threshold 0 and requiredLanes 0 both behave as 1.
        cfg_thr = 0;
        cfg_req = 0;
        fill_good(10);
        run_case(10, 1'b1, dut_e);
        chk("thr0_done_edge", dut_e, 2);

        // More lanes required than exist: timeout only.
        cfg_thr = 3;
        cfg_req = 5;
        cfg_tmo = 12;
        fill_good(20);
        run_case(20, 1'b1, dut_e);
        chk("req_gt_lanes_timeout", bus.timedOut, 1);
        chk("req_gt_lanes_lq", bus.laneQualified, 4'b1111);

        // Mid-run reset discards everything immediately.
        set_default_cfg();
        fill_good(5);
        run_case(5, 1'b0, dut_e);
        reset = 1'b0;
        #1;
        exp_rate = 8'h00;
        exp_upcfg = 1'b0;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_success", bus.success, 0);
        chk("mid_rst_timedout", bus.timedOut, 0);
        chk("mid_rst_lq", bus.laneQualified, 0);
        chk("mid_rst_qc", bus.qualifiedCount, 0);
        chk("mid_rst_rate", bus.rateId, 0);
        chk("mid_rst_upcfg", bus.upConfigureCapability, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        fill_good(20);
        run_case(20, 1'b1, dut_e);
        chk("post_rst_done_edge", dut_e, 9);

        // Randomized runs.
        for (int it = 0; it < 14; it++) begin
            cfg_exp = $urandom_range(1) ? TS1_SYM0 : TS2_SYM0;
            cfg_link = 8'($urandom);
            cfg_chk_link = 1'($urandom_range(1));
            cfg_chk_lane = 1'($urandom_range(1));
            cfg_thr = $urandom_range(0, 6);
            cfg_req = $urandom_range(0, 5);
            cfg_tmo = ($urandom_range(3) == 0) ? 0 : $urandom_range(3, 30);
            for (int e = 0; e <= 40; e++) begin
                vld_tab[e] = ($urandom_range(7) != 0);
                for (int l = 0; l < LANES; l++) begin
                    os_tab[e][l] = mk_os(l, $urandom_range(9) != 0, 8'($urandom));
                end
            end
            run_case(40, 1'b1, dut_e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
